key_encoder_8_3: RTL and testbench
==================================

KEY_ENCODER_8_3 -- requirements
Module: key_encoder_8_3

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchroniser flops per bit; legal range 2..3.
REQ-002 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 sys_rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_req  input  8  asynchronous event lines; bit n rising = event for code n.
REQ-005 out_ready  input  1  consumer accepts out_code this cycle.
REQ-006 out_valid  output  1  out_code holds an undelivered event.
REQ-007 out_code  output  3  binary index of delivered event (inverse of 3-to-8 decode: code n <-> bit n).
REQ-008 out_onehot  output  8  registered one-hot of out_code when out_valid=1; 8'h00 when out_valid=0.
REQ-009 out_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-010 Each in_req bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-011 A prev register SHALL hold the last synchronised value; rise[n] = sync[n] & ~prev[n], combinational.
REQ-012 An 8-bit pending register SHALL set bit n on rise[n].
REQ-013 Output register "free" = out_valid=0, or out_valid=1 and out_ready=1 (transfer).
REQ-014 When free and pending!=0, SHALL load the highest set pending index into out_code, set out_valid=1, and clear that pending bit, all on the same edge.
REQ-015 Priority: bit 7 highest, bit 0 lowest; the selection uses the pending value registered before the edge.
REQ-016 When free and pending==0, out_valid SHALL go 0 on that edge (if a transfer occurred); out_code keeps its last value.
REQ-017 While out_valid=1 and out_ready=0, out_code and out_onehot SHALL remain stable.
REQ-018 Back-to-back: a transfer with pending!=0 SHALL reload on the same edge, keeping out_valid=1 with no bubble.
REQ-019 Rise on bit n while pending[n]=1 and bit n not being loaded that edge: event dropped, out_overflow set to 1.
REQ-020 Rise on bit n in the same edge that pending[n] is cleared by a load: pending[n] SHALL remain 1 (new event kept, no overflow).
REQ-021 Rise on bit n while code n is in the output register only (pending[n]=0): pending[n] set, no overflow.
REQ-022 out_overflow SHALL clear only on reset.
REQ-023 Latency: in_req[n] rising before edge 1 -> out_valid=1 after edge SYNC_STAGES+2 (4 for default), given empty pipeline.
REQ-024 Level held high SHALL generate exactly one event; a new event requires a low level for at least one synchronised cycle.
REQ-025 Throughput: one event per cycle when out_ready is held 1.

Reset
REQ-026 On a sys_clk edge with sys_rst_n=0: synchroniser, prev, pending = 8'h00; out_valid=0; out_code=3'd0; out_onehot=8'h00; out_overflow=0.
REQ-027 Reset mid-operation SHALL discard pending and held events; no out_valid for them after release.
REQ-028 in_req already high at reset release: synchroniser fills from 0, so it SHALL count as one rising event.
REQ-029 Outputs SHALL not change asynchronously to sys_clk.

Verification
REQ-030 Single event: out_ready=1, in_req 8'h00->8'h20 -> after 4 edges out_valid=1 for 1 cycle, out_code=5, out_onehot=8'h20.
REQ-031 Priority and stall: in_req 8'h00->8'h81 same cycle, out_ready=0 -> out_code=7 held stable; then out_ready=1 -> code 7, then code 0 on consecutive cycles, then out_valid=0.
REQ-032 Overflow: out_ready=0, pulse bit 3 twice (2-cycle low gap) while code 3 pending behind held code 6 -> out_overflow=1; later deliveries: 6, 3 only.
REQ-033 Simultaneous set/clear: rise[2] on the same edge pending[2] is loaded -> code 2 delivered twice, out_overflow=0.
REQ-034 Reset mid-stall: out_valid=1, pending=8'h0C, sys_rst_n=0 for 1 edge -> all outputs at reset values; no further out_valid without new edges.
REQ-035 Held level: in_req=8'hFF held 20 cycles, out_ready=1 -> exactly codes 7,6,5,4,3,2,1,0 once each, back-to-back.

Source files
------------

// File: rtl/key_encoder_8_3.sv
// rtl/key_encoder_8_3.sv - synchronised 8-line event capture with priority encode to a 3-bit code stream
module key_encoder_8_3 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] in_req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] out_onehot,
    output logic       out_overflow
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] prev_q;
    logic [7:0] pending_q, pending_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] out_code_q, out_code_d;
    logic [7:0] out_onehot_q, out_onehot_d;
    logic       overflow_q, overflow_d;

    logic [7:0] rise;
    logic [7:0] load_mask;
    logic [2:0] sel;
    logic       free;
    logic       load;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
        end else begin
            sync_q[0] <= in_req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign free = ~out_valid_q | out_ready;
    assign load = free & (|pending_q);

    // Ascending scan so the highest pending index is the one that sticks.
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign load_mask = load ? (8'h01 << sel) : 8'h00;

    always_comb begin
        pending_d    = (pending_q & ~load_mask) | rise;
        overflow_d   = overflow_q | (|(rise & pending_q & ~load_mask));
        out_valid_d  = out_valid_q;
        out_code_d   = out_code_q;
        out_onehot_d = out_onehot_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_code_d   = sel;
            out_onehot_d = 8'h01 << sel;
        end else if (free) begin
            out_valid_d  = 1'b0;
            out_onehot_d = 8'h00;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_q       <= 8'h00;
            pending_q    <= 8'h00;
            out_valid_q  <= 1'b0;
            out_code_q   <= 3'd0;
            out_onehot_q <= 8'h00;
            overflow_q   <= 1'b0;
        end else begin
            prev_q       <= sync_q[SYNC_STAGES-1];
            pending_q    <= pending_d;
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            out_onehot_q <= out_onehot_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_code     = out_code_q;
    assign out_onehot   = out_onehot_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_key_encoder_8_3.sv
// tb/tb_key_encoder_8_3.sv - directed self-checking bench for key_encoder_8_3
module tb_key_encoder_8_3;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] in_req = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] out_onehot;
    logic       out_overflow;

    int n_cmp = 0;
    int n_err = 0;

    key_encoder_8_3 #(.SYNC_STAGES(2)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .in_req       (in_req),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_code     (out_code),
        .out_onehot   (out_onehot),
        .out_overflow (out_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        in_req    = 8'h00;
        out_ready = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic [7:0] oh);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_code"}, 32'(out_code), 32'(c));
        chk({tag, "_onehot"}, 32'(out_onehot), 32'(oh));
    endtask

    initial begin
        // Reset state
        tick(2);
        chk_out("rst", 1'b0, 3'd0, 8'h00);
        chk("rst_ovf", 32'(out_overflow), 32'd0);
        sys_rst_n = 1'b1;
        tick(1);

        // Single event, latency 4 edges
        out_ready = 1'b1;
        in_req = 8'h20;
        tick(3);
        chk("single_pre_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk_out("single", 1'b1, 3'd5, 8'h20);
        tick(1);
        chk_out("single_done", 1'b0, 3'd5, 8'h00);
        tick(3);
        chk("single_once", 32'(out_valid), 32'd0);

        // Priority and stall
        do_reset();
        in_req = 8'h81;
        tick(4);
        chk_out("prio_hold0", 1'b1, 3'd7, 8'h80);
        tick(3);
        chk_out("prio_hold3", 1'b1, 3'd7, 8'h80);
        out_ready = 1'b1;
        tick(1);
        chk_out("prio_second", 1'b1, 3'd0, 8'h01);
        tick(1);
        chk_out("prio_empty", 1'b0, 3'd0, 8'h00);

        // Overflow: code 3 pending behind held code 6, bit 3 pulsed again
        do_reset();
        in_req = 8'h48;
        tick(4);
        chk_out("ovf_held", 1'b1, 3'd6, 8'h40);
        chk("ovf_pre", 32'(out_overflow), 32'd0);
        in_req = 8'h40;
        tick(2);
        in_req = 8'h48;
        tick(4);
        chk("ovf_set", 32'(out_overflow), 32'd1);
        chk_out("ovf_still_held", 1'b1, 3'd6, 8'h40);
        out_ready = 1'b1;
        tick(1);
        chk_out("ovf_deliver3", 1'b1, 3'd3, 8'h08);
        tick(1);
        chk_out("ovf_empty", 1'b0, 3'd3, 8'h00);
        tick(3);
        chk("ovf_sticky", 32'(out_overflow), 32'd1);

        // Simultaneous set and clear of pending[2]
        do_reset();
        in_req = 8'h84;
        tick(4);
        chk_out("sc_held", 1'b1, 3'd7, 8'h80);
        in_req = 8'h80;
        tick(2);
        in_req = 8'h84;
        tick(2);
        out_ready = 1'b1;
        tick(1);
        chk_out("sc_first2", 1'b1, 3'd2, 8'h04);
        tick(1);
        chk_out("sc_second2", 1'b1, 3'd2, 8'h04);
        tick(1);
        chk_out("sc_empty", 1'b0, 3'd2, 8'h00);
        chk("sc_ovf", 32'(out_overflow), 32'd0);

        // Reset mid-stall with pending 8'h0C
        do_reset();
        in_req = 8'h8C;
        tick(4);
        chk_out("rms_held", 1'b1, 3'd7, 8'h80);
        sys_rst_n = 1'b0;
        in_req = 8'h00;
        tick(1);
        chk_out("rms_rst", 1'b0, 3'd0, 8'h00);
        chk("rms_ovf", 32'(out_overflow), 32'd0);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("rms_quiet", 32'(out_valid), 32'd0);
        end

        // Level already high at reset release counts as one event
        sys_rst_n = 1'b0;
        in_req = 8'h10;
        tick(2);
        sys_rst_n = 1'b1;
        tick(3);
        chk("rel_pre", 32'(out_valid), 32'd0);
        tick(1);
        chk_out("rel_evt", 1'b1, 3'd4, 8'h10);
        tick(1);
        chk("rel_once", 32'(out_valid), 32'd0);

        // Held level 8'hFF: each code exactly once, back-to-back
        do_reset();
        out_ready = 1'b1;
        in_req = 8'hFF;
        tick(3);
        chk("ff_pre", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk_out("ff_seq", 1'b1, 3'(7 - i), 8'h01 << (7 - i));
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("ff_after", 32'(out_valid), 32'd0);
        end
        chk("ff_ovf", 32'(out_overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
